// File: rtl/cache_ctrl.sv
// MESI/LRU controller in front of the set-associative cache array: one trace command
// at a time, LOOKUP reads the set, UPDATE writes it back modified, RESP reports.
module cache_ctrl #(
    parameter int SETS  = 16384,
    parameter int WAYS  = 8,
    parameter int TAG_W = 12,
    localparam int SET_W  = $clog2(SETS),
    localparam int AGE_W  = $clog2(WAYS),
    localparam int LINE_W = 2 + AGE_W + TAG_W,
    localparam int CMD_W  = 4 + TAG_W + SET_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [CMD_W-1:0]         req_cmd,
    output logic [CMD_W-1:0]         array_cmd,
    input  logic [WAYS*LINE_W-1:0]   array_rd,
    output logic [WAYS*LINE_W-1:0]   array_wr,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output logic [AGE_W-1:0]         resp_way,
    output logic [1:0]               resp_bus_op,
    output logic [1:0]               resp_snoop,
    output logic                     resp_evict,
    output logic [TAG_W-1:0]         resp_evict_tag
);
    // Command word is {n[3:0], tag, set_index}; a line is {mesi[1:0], age, tag}.
    localparam logic [1:0] MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3;
    localparam logic [1:0] BUS_NONE = 2'd0, BUS_READ = 2'd1, BUS_RWIM = 2'd2, BUS_INV = 2'd3;
    localparam logic [1:0] SNP_NOHIT = 2'd0, SNP_HIT = 2'd1, SNP_HITM = 2'd2;
    localparam logic [CMD_W-1:0] NOP_CMD = {4'd7, {(CMD_W-4){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_PASS, S_RESP} state_t;

    state_t                       state, nxt;
    logic [CMD_W-1:0]             cmd_q;
    logic [WAYS-1:0][LINE_W-1:0]  buf_q, new_lines;
    logic [3:0]                   cmd_n, req_n;
    logic [TAG_W-1:0]             cmd_tag;

    assign cmd_n   = cmd_q[CMD_W-1 -: 4];
    assign cmd_tag = cmd_q[SET_W +: TAG_W];
    assign req_n   = req_cmd[CMD_W-1 -: 4];

    logic [WAYS-1:0][1:0]         b_mesi;
    logic [WAYS-1:0][AGE_W-1:0]   b_age;
    logic [WAYS-1:0][TAG_W-1:0]   b_tag;

    for (genvar g = 0; g < WAYS; g++) begin : g_unpack
        assign b_mesi[g] = buf_q[g][LINE_W-1 -: 2];
        assign b_age[g]  = buf_q[g][TAG_W +: AGE_W];
        assign b_tag[g]  = buf_q[g][TAG_W-1:0];
    end

    logic             hit, has_inv, evict;
    logic [AGE_W-1:0] hit_way, inv_way, lru_way, sel_way, rsp_way;
    logic [1:0]       bus_op, snoop;
    logic [TAG_W-1:0] evict_tag;

    always_comb begin
        hit       = 1'b0;
        has_inv   = 1'b0;
        hit_way   = '0;
        inv_way   = '0;
        lru_way   = '0;
        // Descending scan so the lowest matching index wins.
        for (int w = WAYS-1; w >= 0; w--) begin
            if (b_mesi[w] != MESI_I && b_tag[w] == cmd_tag) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
            if (b_mesi[w] == MESI_I) begin
                has_inv = 1'b1;
                inv_way = AGE_W'(w);
            end
            if (b_age[w] == AGE_W'(WAYS-1))
                lru_way = AGE_W'(w);
        end
        sel_way = hit ? hit_way : (has_inv ? inv_way : lru_way);

        new_lines = buf_q;
        bus_op    = BUS_NONE;
        snoop     = SNP_NOHIT;
        evict     = 1'b0;
        evict_tag = '0;
        rsp_way   = sel_way;

        if (cmd_n <= 4'd2) begin
            for (int w = 0; w < WAYS; w++)
                if (b_age[w] < b_age[sel_way])
                    new_lines[w][TAG_W +: AGE_W] = b_age[w] + 1'b1;
            new_lines[sel_way][TAG_W +: AGE_W] = '0;
            if (!hit) begin
                new_lines[sel_way][TAG_W-1:0] = cmd_tag;
                evict = (b_mesi[sel_way] == MESI_M);
                if (evict)
                    evict_tag = b_tag[sel_way];
            end
            if (cmd_n == 4'd1) begin
                new_lines[sel_way][LINE_W-1 -: 2] = MESI_M;
                if (!hit)
                    bus_op = BUS_RWIM;
                else if (b_mesi[sel_way] == MESI_S)
                    bus_op = BUS_INV;
            end else if (!hit) begin
                new_lines[sel_way][LINE_W-1 -: 2] = MESI_E;
                bus_op = BUS_READ;
            end
        end else if (cmd_n <= 4'd4) begin
            // Snoops leave ages alone and report way 0 when nothing matches.
            rsp_way = hit ? hit_way : '0;
            if (hit) begin
                snoop = (b_mesi[hit_way] == MESI_M) ? SNP_HITM : SNP_HIT;
                new_lines[hit_way][LINE_W-1 -: 2] = (cmd_n == 4'd3) ? MESI_S : MESI_I;
            end
        end
    end

    always_comb begin
        nxt       = state;
        req_ready = 1'b0;
        array_cmd = NOP_CMD;
        array_wr  = array_rd;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_n <= 4'd4)
                        nxt = S_LOOKUP;
                    else if (req_n == 4'd8 || req_n == 4'd9)
                        nxt = S_PASS;
                    else
                        nxt = S_RESP;
                end
            end
            S_LOOKUP: begin
                array_cmd = cmd_q;
                nxt       = S_UPDATE;
            end
            S_UPDATE: begin
                array_cmd = cmd_q;
                array_wr  = new_lines;
                nxt       = S_RESP;
            end
            S_PASS: begin
                array_cmd = cmd_q;
                nxt       = S_RESP;
            end
            S_RESP:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cmd_q          <= '0;
            buf_q          <= '0;
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_way       <= '0;
            resp_bus_op    <= '0;
            resp_snoop     <= '0;
            resp_evict     <= 1'b0;
            resp_evict_tag <= '0;
        end else begin
            state      <= nxt;
            resp_valid <= (nxt == S_RESP);
            if (state == S_IDLE && req_valid)
                cmd_q <= req_cmd;
            if (state == S_LOOKUP)
                buf_q <= array_rd;
            if (state == S_UPDATE) begin
                resp_hit       <= hit;
                resp_way       <= rsp_way;
                resp_bus_op    <= bus_op;
                resp_snoop     <= snoop;
                resp_evict     <= evict;
                resp_evict_tag <= evict_tag;
            end else if (nxt == S_RESP) begin
                resp_hit       <= 1'b0;
                resp_way       <= '0;
                resp_bus_op    <= BUS_NONE;
                resp_snoop     <= SNP_NOHIT;
                resp_evict     <= 1'b0;
                resp_evict_tag <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural array model, vector table with hand-derived
// responses, scoreboard queue, plus reset and pass-through corner sequences.
module tb_cache_ctrl;
    localparam int SETS = 16384, WAYS = 8, TAG_W = 12;
    localparam int SET_W = 14, AGE_W = 3, LINE_W = 17, CMD_W = 30;

    logic                   clk, rst_n, req_valid, req_ready;
    logic [CMD_W-1:0]       req_cmd, array_cmd;
    logic [WAYS*LINE_W-1:0] array_rd, array_wr;
    logic                   resp_valid, resp_hit, resp_evict;
    logic [AGE_W-1:0]       resp_way;
    logic [1:0]             resp_bus_op, resp_snoop;
    logic [TAG_W-1:0]       resp_evict_tag;

    cache_ctrl #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .array_cmd(array_cmd), .array_rd(array_rd), .array_wr(array_wr),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
        .resp_bus_op(resp_bus_op), .resp_snoop(resp_snoop), .resp_evict(resp_evict),
        .resp_evict_tag(resp_evict_tag)
    );

    typedef struct packed {
        logic       hit;
        logic [2:0] way;
        logic [1:0] bus;
        logic [1:0] snp;
        logic       ev;
        logic [11:0] etag;
    } rsp_t;

    typedef struct {
        logic [3:0]  n;
        logic [11:0] tag;
        logic [13:0] set;
        rsp_t        exp;
        int          lat;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   n8_cnt = 0;
    rsp_t sbq[$];
    vec_t vt[$];
    logic [LINE_W-1:0] mem [SETS][WAYS];
    logic [LINE_W-1:0] snap [WAYS];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Array model: ages start as a permutation with way 0 oldest; commit at end of high phase.
    initial begin
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                mem[s][w] = {2'b00, 3'(WAYS-1-w), 12'h000};
        forever begin
            @(negedge clk);
            if (array_cmd[CMD_W-1 -: 4] <= 4'd4)
                for (int w = 0; w < WAYS; w++)
                    mem[array_cmd[SET_W-1:0]][w] = array_wr[w*LINE_W +: LINE_W];
        end
    end

    always_comb begin
        array_rd = '0;
        for (int w = 0; w < WAYS; w++)
            array_rd[w*LINE_W +: LINE_W] = mem[array_cmd[SET_W-1:0]][w];
    end

    always @(negedge clk)
        if (array_cmd[CMD_W-1 -: 4] == 4'd8) n8_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] f_mesi(input logic [LINE_W-1:0] l); return l[16:15]; endfunction
    function automatic logic [2:0] f_age(input logic [LINE_W-1:0] l);  return l[14:12]; endfunction
    function automatic logic [11:0] f_tag(input logic [LINE_W-1:0] l); return l[11:0];  endfunction

    function automatic logic is_perm(input int s);
        logic [WAYS-1:0] seen = '0;
        for (int w = 0; w < WAYS; w++) seen[f_age(mem[s][w])] = 1'b1;
        return &seen;
    endfunction

    function automatic vec_t mk(input int n, input int tag, input int set, input int hit,
                                input int way, input int bus, input int snp, input int ev,
                                input int etag);
        vec_t v;
        v.n   = 4'(n);
        v.tag = 12'(tag);
        v.set = 14'(set);
        v.exp = '{hit: 1'(hit), way: 3'(way), bus: 2'(bus), snp: 2'(snp), ev: 1'(ev), etag: 12'(etag)};
        v.lat = (n <= 4) ? 3 : ((n == 8 || n == 9) ? 2 : 1);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    function automatic rsp_t cur_rsp();
        return {resp_hit, resp_way, resp_bus_op, resp_snoop, resp_evict, resp_evict_tag};
    endfunction

    task automatic send(input vec_t v);
        int   lat;
        rsp_t e;
        chk("ready_idle", req_ready, 1);
        req_valid = 1;
        req_cmd   = {v.n, v.tag, v.set};
        sbq.push_back(v.exp);
        @(posedge clk); #1;
        req_valid = 0;
        lat = 1;
        // Junk requests while busy must be ignored.
        while (!resp_valid && lat < 12) begin
            req_valid = 1;
            req_cmd   = {4'($urandom_range(0, 9)), 26'($urandom)};
            @(posedge clk); #1;
            req_valid = 0;
            lat++;
        end
        e = sbq.pop_front();
        if (!resp_valid) chk("resp_timeout", 0, 1);
        else             chk("resp", cur_rsp(), e);
        chk("latency", lat, v.lat);
        @(posedge clk); #1;
        chk("resp_valid_oneshot", resp_valid, 0);
    endtask

    initial begin
        int pulses, n8_start;
        rst_n = 0; req_valid = 0; req_cmd = '0;

        repeat (3) @(posedge clk); #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_array_cmd", array_cmd, {4'd7, 26'd0});
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp", cur_rsp(), 0);
        chk("rst_wr_passthru", array_wr == array_rd, 1);
        rst_n = 1;
        @(posedge clk); #1;

        vt.push_back(mk(0, 'hABC, 5, 0, 0, 1, 0, 0, 0));   // 0 read miss -> E
        vt.push_back(mk(0, 'hABC, 5, 1, 0, 0, 0, 0, 0));   // 1 read hit
        vt.push_back(mk(1, 'hABC, 5, 1, 0, 0, 0, 0, 0));   // 2 write hit E -> M
        vt.push_back(mk(3, 'hABC, 5, 1, 0, 0, 2, 0, 0));   // 3 snoop read M -> S, HITM
        vt.push_back(mk(1, 'hABC, 5, 1, 0, 3, 0, 0, 0));   // 4 write hit S -> M, INVALIDATE
        vt.push_back(mk(1, 'h100, 7, 0, 0, 2, 0, 0, 0));   // 5 write miss -> M, RWIM
        for (int k = 0; k < 7; k++)
            vt.push_back(mk(0, 'h101 + k, 7, 0, 1 + k, 1, 0, 0, 0)); // 6..12 fills
        vt.push_back(mk(0, 'h108, 7, 0, 0, 1, 0, 1, 'h100)); // 13 LRU evicts M way 0
        vt.push_back(mk(3, 'h101, 7, 1, 1, 0, 1, 0, 0));   // 14 snoop read E -> S, HIT
        vt.push_back(mk(1, 'h101, 7, 1, 1, 3, 0, 0, 0));   // 15 write hit S, oldest way
        vt.push_back(mk(4, 'h555, 5, 0, 0, 0, 0, 0, 0));   // 16 snoop inval miss
        vt.push_back(mk(4, 'hABC, 5, 1, 0, 0, 2, 0, 0));   // 17 snoop inval M -> I
        vt.push_back(mk(2, 'hABC, 5, 0, 0, 1, 0, 0, 0));   // 18 ifetch miss refills way 0
        vt.push_back(mk(2, 'hABC, 5, 1, 0, 0, 0, 0, 0));   // 19 ifetch hit
        vt.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0));       // 20 no-op
        vt.push_back(mk(8, 0, 0, 0, 0, 0, 0, 0, 0));       // 21 clear
        vt.push_back(mk(9, 0, 0, 0, 0, 0, 0, 0, 0));       // 22 print
        vt.push_back(mk(15, 0, 0, 0, 0, 0, 0, 0, 0));      // 23 no-op

        for (int i = 0; i < vt.size(); i++) begin
            for (int w = 0; w < WAYS; w++) snap[w] = mem[vt[i].set][w];
            n8_start = n8_cnt;
            send(vt[i]);
            case (i)
                0: begin
                    chk("i0_mesi", f_mesi(mem[5][0]), 2);
                    chk("i0_tag", f_tag(mem[5][0]), 'hABC);
                    chk("i0_age0", f_age(mem[5][0]), 0);
                    chk("i0_age1", f_age(mem[5][1]), 7);
                    chk("i0_age7", f_age(mem[5][7]), 1);
                    chk("i0_perm", is_perm(5), 1);
                end
                1: chk("i1_mesi", f_mesi(mem[5][0]), 2);
                2: chk("i2_mesi", f_mesi(mem[5][0]), 3);
                3: begin
                    chk("i3_mesi", f_mesi(mem[5][0]), 1);
                    for (int w = 0; w < WAYS; w++)
                        chk("i3_age_kept", f_age(mem[5][w]), f_age(snap[w]));
                end
                4: chk("i4_mesi", f_mesi(mem[5][0]), 3);
                13: begin
                    chk("i13_tag", f_tag(mem[7][0]), 'h108);
                    chk("i13_mesi", f_mesi(mem[7][0]), 2);
                    chk("i13_age", f_age(mem[7][0]), 0);
                    chk("i13_perm", is_perm(7), 1);
                end
                15: begin
                    chk("i15_mesi", f_mesi(mem[7][1]), 3);
                    chk("i15_age1", f_age(mem[7][1]), 0);
                    chk("i15_age0", f_age(mem[7][0]), 1);
                    chk("i15_perm", is_perm(7), 1);
                end
                16: for (int w = 0; w < WAYS; w++)
                        chk("i16_unchanged", mem[5][w], snap[w]);
                17: chk("i17_mesi", f_mesi(mem[5][0]), 0);
                21: chk("clear_one_cycle", n8_cnt - n8_start, 1);
                default: ;
            endcase
        end

        // Reset during UPDATE: command is dropped, controller idles immediately.
        send(mk(1, 'h333, 9, 0, 0, 2, 0, 0, 0));
        req_valid = 1;
        req_cmd   = {4'd0, 12'h777, 14'd9};
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("midrst_ready", req_ready, 1);
        chk("midrst_cmd_n", array_cmd[CMD_W-1 -: 4], 7);
        chk("midrst_resp", cur_rsp(), 0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) rst_n = 1;
            if (resp_valid) pulses++;
        end
        chk("midrst_no_resp", pulses, 0);
        send(mk(0, 'h333, 9, 1, 0, 0, 0, 0, 0));
        chk("sb_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Sequential controller that sits directly upstream of the set-associative `cache` array. It accepts one trace command at a time, drives the array's `instruction`, `cache_in` and `cache_out` ports, and performs tag compare, hit/miss, victim selection, MESI next-state and LRU age update. It returns a per-command response (hit, way, bus operation, snoop result, eviction) to the trace driver.

## Interface
- `SETS`, 16384: sets in the array.
- `WAYS`, 8: associativity. LRU ages are `$clog2(WAYS)` bits wide.
- `TAG_W`, 12: tag width in `cache_line_t`.
- `clk`  in  1  single clock; the array reads while `clk` is low and commits while `clk` is high.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  `req_cmd` is valid.
- `req_ready`  out  1  controller can accept a command; high only in IDLE.
- `req_cmd`  in  `command_t`  command code `n` plus address (`tag`, `set_index`).
- `array_cmd`  out  `command_t`  drives the array's `instruction` port.
- `array_rd`  in  `cache_line_t[WAYS]`  from the array's `cache_out`.
- `array_wr`  out  `cache_line_t[WAYS]`  to the array's `cache_in`.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_hit`  out  1  tag match with MESI != I.
- `resp_way`  out  `$clog2(WAYS)`  hit way, or filled way on a miss.
- `resp_bus_op`  out  2  0 NONE, 1 READ, 2 RWIM, 3 INVALIDATE.
- `resp_snoop`  out  2  0 NOHIT, 1 HIT, 2 HITM.
- `resp_evict`  out  1  victim was in state M; a writeback is required.
- `resp_evict_tag`  out  `TAG_W`  tag of the evicted M line.

## Operation
- Command codes:
  - 0 data read, 1 data write, 2 instruction read (processor side).
  - 3 snooped read, 4 snooped invalidate (snoop side).
  - 8 clear, 9 print.
  - Any other code is a no-op.
- FSM states: IDLE, LOOKUP, UPDATE, PASS, RESP.
- IDLE: `req_ready`=1 and `array_cmd.n`=7 (no-op).
  - Handshake `req_valid && req_ready` captures `req_cmd`.
  - n in 0..4 goes to LOOKUP; n = 8 or 9 goes to PASS; any other n goes to RESP.
- LOOKUP:
  - `array_cmd` = captured command.
  - `array_wr` = `array_rd`, so the array's high-phase commit is idempotent.
  - At the clock edge, register `array_rd` into the line buffer.
  - Hit way = lowest-index way with matching tag and MESI != I.
- UPDATE:
  - `array_cmd` = captured command.
  - `array_wr` = line buffer with the updated way(s); the array commits during this cycle.
  - Next state: RESP.
- PASS: `array_cmd` = captured command for exactly one cycle, then RESP.
- RESP: `resp_valid`=1 for one cycle, `array_cmd.n`=7, then IDLE.
- Victim on a miss: the lowest-index way with MESI=I. If there is none, the way whose age is `WAYS-1`.
- MESI, processor side:
  - Read (0, 2), hit: state unchanged, bus_op NONE.
  - Read (0, 2), miss: fill the victim with the tag in state E, bus_op READ.
  - Write (1), hit in M or E: go to M, bus_op NONE.
  - Write (1), hit in S: go to M, bus_op INVALIDATE.
  - Write (1), miss: fill the victim in state M, bus_op RWIM.
  - On any fill of a victim in state M: `resp_evict`=1 and `resp_evict_tag` = the old tag.
- MESI, snoop side (LRU is not touched):
  - Snooped read (3): M goes to S with HITM; E or S goes to S with HIT; a miss gives NOHIT.
  - Snooped invalidate (4): any valid line goes to I; HITM if it was M, otherwise HIT; a miss gives NOHIT.
- LRU (processor commands only): ages 0 = MRU to `WAYS-1` = LRU.
  - When touching a way of age a, every way with age < a increments and the touched way becomes 0.
  - The ages in a set always form a permutation of 0..`WAYS-1`.
- Commands 8, 9 and no-ops respond with `resp_hit`=0, bus_op NONE, snoop NOHIT, evict 0.

## Timing
- Latency for n = 0..4, measured from the accept edge:
  - LOOKUP occupies cycle 1 and UPDATE occupies cycle 2.
  - `resp_valid` is high in cycle 3.
  - Throughput is one command per 4 cycles.
- n = 8 or 9: `resp_valid` in cycle 2. No-op codes: `resp_valid` in cycle 1.
- All `resp_*` outputs are registered and hold their value until the next RESP.
- Reset values:
  - FSM = IDLE, `req_ready`=1, `array_cmd` = 0 with n=7.
  - All `resp_*` = 0.
  - `array_wr` = `array_rd` (combinational).
- Reset asserted mid-command: the command is dropped with no response. If reset hits in UPDATE, that partial commit is the array's concern; the controller issues nothing further.
- `req_valid` is ignored while `req_ready`=0, and `req_cmd` may change freely then.

## Test plan
- After reset, send read 0 to tag 0xABC, set 5 → miss, way 0, bus_op READ, way 0 in state E with age 0, other ages incremented; response in cycle 3.
- Repeat the same read → hit, way 0, bus_op NONE, state stays E; then write (1) → state M, bus_op NONE.
- Snooped read (3) to that M line → HITM, state S, ages unchanged. Then write (1) → M with bus_op INVALIDATE.
- Fill 9 distinct tags into set 7 with the first tag written → the 9th fill evicts way 0, `resp_evict`=1, `resp_evict_tag` = the first tag; ages remain a permutation.
- Snooped invalidate (4) to a non-resident tag → NOHIT, array contents unchanged; command 8 → `array_cmd.n`=8 for one cycle, response in cycle 2.
- Assert `rst_n`=0 during UPDATE → `resp_valid` never pulses for that command; `req_ready`=1 immediately and `array_cmd.n`=7.
